// File: rtl/alut_age_sweep12.sv
// ALUT aging engine: sweeps all entries through the RAM age port and invalidates stale ones.
// Optional ALUT_AGE_AUTO_SWEEP_EN adds a free-running interval timer that starts sweeps itself.
module alut_age_sweep12 #(
    parameter int unsigned DW             = 83,
    parameter int unsigned DD             = 256,
    parameter logic [31:0] SWEEP_INTERVAL = 32'd100000
) (
    input  logic          pclk12,
    input  logic          p_reset12,
    input  logic          age_start12,
    input  logic [31:0]   curr_time12,
    input  logic [31:0]   age_thresh12,
    input  logic [DW-1:0] mem_read_data_age12,
    input  logic [7:0]    mem_addr_add12,
    input  logic          mem_write_add12,
    output logic [7:0]    mem_addr_age12,
    output logic          mem_write_age12,
    output logic [DW-1:0] mem_write_data_age12,
    output logic          sweep_busy12,
    output logic          sweep_done12,
    output logic [8:0]    aged_count12
);

    localparam int unsigned VldBit = 82;

    typedef enum logic [2:0] {StIdle, StRd, StChk, StWr, StDone} state_e;

    state_e        state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [8:0]    aged_q, aged_d;
    logic          coll_q, coll_d;
    logic [DW-1:0] data_q, data_d;

    logic          add_hit;
    logic          last;
    logic          start;
    logic [31:0]   age;
    logic [DW-1:0] wdata;

    assign add_hit = mem_write_add12 && (mem_addr_add12 == idx_q);
    assign last    = (idx_q == 8'(DD - 1));
    // Modular subtraction keeps timestamps that wrapped past 2^32 correct.
    assign age     = curr_time12 - mem_read_data_age12[79:48];

`ifdef ALUT_AGE_AUTO_SWEEP_EN
    logic [31:0] intv_q, intv_d;

    assign start = age_start12 || (intv_q == SWEEP_INTERVAL - 32'd1);

    always_comb begin
        intv_d = 32'd0;
        if (state_q == StIdle && !start) begin
            intv_d = intv_q + 32'd1;
        end
    end

    always_ff @(posedge pclk12) begin
        if (p_reset12) begin
            intv_q <= 32'd0;
        end else begin
            intv_q <= intv_d;
        end
    end
`else
    assign start = age_start12;
`endif

    always_comb begin
        wdata         = data_q;
        wdata[VldBit] = 1'b0;
    end

    assign mem_addr_age12       = idx_q;
    assign mem_write_age12      = (state_q == StWr) && !add_hit && !p_reset12;
    assign mem_write_data_age12 = (state_q == StWr) ? wdata : '0;
    assign sweep_busy12         = (state_q == StRd) || (state_q == StChk) || (state_q == StWr);
    assign sweep_done12         = (state_q == StDone);
    assign aged_count12         = aged_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        aged_d  = aged_q;
        coll_d  = coll_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRd;
                    idx_d   = 8'd0;
                    cnt_d   = 9'd0;
                    coll_d  = 1'b0;
                end
            end
            StRd: begin
                coll_d  = coll_q || add_hit;
                state_d = StChk;
            end
            StChk: begin
                data_d = mem_read_data_age12;
                if (mem_read_data_age12[VldBit] && (age > age_thresh12) && !(coll_q || add_hit)) begin
                    state_d = StWr;
                end else begin
                    coll_d  = 1'b0;
                    idx_d   = last ? idx_q : idx_q + 8'd1;
                    state_d = last ? StDone : StRd;
                end
            end
            StWr: begin
                if (mem_write_age12) begin
                    cnt_d = cnt_q + 9'd1;
                end
                coll_d  = 1'b0;
                idx_d   = last ? idx_q : idx_q + 8'd1;
                state_d = last ? StDone : StRd;
            end
            StDone: begin
                aged_d  = cnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk12) begin
        if (p_reset12) begin
            state_q <= StIdle;
            idx_q   <= 8'd0;
            cnt_q   <= 9'd0;
            aged_q  <= 9'd0;
            coll_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            aged_q  <= aged_d;
            coll_q  <= coll_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_alut_age_sweep12.sv
// Bench for alut_age_sweep12: behavioural RAM plus a table-level aging model.
module tb_alut_age_sweep12;

    localparam int DW = 83;

    logic          pclk12 = 1'b0;
    logic          p_reset12;
    logic          age_start12;
    logic [31:0]   curr_time12;
    logic [31:0]   age_thresh12;
    logic [DW-1:0] mem_read_data_age12;
    logic [7:0]    mem_addr_add12;
    logic          mem_write_add12;
    logic [7:0]    mem_addr_age12;
    logic          mem_write_age12;
    logic [DW-1:0] mem_write_data_age12;
    logic          sweep_busy12;
    logic          sweep_done12;
    logic [8:0]    aged_count12;

    logic [DW-1:0] ram      [256];
    logic [DW-1:0] init_tab [256];
    logic [DW-1:0] exp_tab  [256];
    logic [DW-1:0] add_data;
    logic          ld_all;

    int n_vec  = 0;
    int n_fail = 0;

    alut_age_sweep12 dut (
        .pclk12               (pclk12),
        .p_reset12            (p_reset12),
        .age_start12          (age_start12),
        .curr_time12          (curr_time12),
        .age_thresh12         (age_thresh12),
        .mem_read_data_age12  (mem_read_data_age12),
        .mem_addr_add12       (mem_addr_add12),
        .mem_write_add12      (mem_write_add12),
        .mem_addr_age12       (mem_addr_age12),
        .mem_write_age12      (mem_write_age12),
        .mem_write_data_age12 (mem_write_data_age12),
        .sweep_busy12         (sweep_busy12),
        .sweep_done12         (sweep_done12),
        .aged_count12         (aged_count12)
    );

    always #5 pclk12 = ~pclk12;

    // Shared ALUT RAM: registered read, age and add write ports.
    always @(posedge pclk12) begin
        if (ld_all) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_tab[i];
        end else begin
            if (mem_write_age12) ram[mem_addr_age12] <= mem_write_data_age12;
            if (mem_write_add12) ram[mem_addr_add12] <= add_data;
        end
        mem_read_data_age12 <= ram[mem_addr_age12];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_entry(input logic v, input logic [31:0] ts);
        logic [1:0]  port;
        logic [47:0] mac;
        port = 2'($urandom);
        mac  = {16'($urandom), $urandom};
        return {v, port, ts, mac};
    endfunction

    task automatic fill_invalid();
        for (int i = 0; i < 256; i++) init_tab[i] = mk_entry(1'b0, $urandom);
    endtask

    task automatic load_table();
        ld_all = 1'b1;
        @(negedge pclk12);
        ld_all = 1'b0;
    endtask

    // Expected table after a sweep: stale valid entries lose their valid bit.
    task automatic build_expect(input int coll, output int n);
        logic [31:0] a;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            exp_tab[i] = init_tab[i];
            if (i == coll) begin
                exp_tab[i] = add_data;
            end else begin
                a = curr_time12 - init_tab[i][79:48];
                if (init_tab[i][82] && a > age_thresh12) begin
                    exp_tab[i][82] = 1'b0;
                    n++;
                end
            end
        end
    endtask

    task automatic run_sweep(input int coll, output int busy_n, output int done_at,
                             output int wr_n, output int wr_addr, output int first_addr);
        int phase;
        busy_n = 0; done_at = -1; wr_n = 0; wr_addr = -1; first_addr = -1; phase = 0;
        age_start12 = 1'b1;
        @(negedge pclk12);
        age_start12 = 1'b0;
        for (int k = 1; k < 2000; k++) begin
            if (k == 1) first_addr = int'(mem_addr_age12);
            if (mem_write_age12) begin
                wr_n++;
                wr_addr = int'(mem_addr_age12);
            end
            if (sweep_busy12) busy_n++;
            if (sweep_done12) begin
                done_at = k;
                break;
            end
            if (phase == 1) begin
                mem_write_add12 = 1'b1;
                mem_addr_add12  = 8'(coll);
                phase = 2;
            end else if (phase == 2) begin
                mem_write_add12 = 1'b0;
                phase = 3;
            end else if (phase == 0 && coll < 256 && sweep_busy12 &&
                         int'(mem_addr_age12) == coll) begin
                phase = 1;
            end
            @(negedge pclk12);
        end
        mem_write_add12 = 1'b0;
    endtask

    task automatic check_table(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== exp_tab[i]) mism++;
        chk({tag, " table"}, 64'(mism), 64'd0);
    endtask

    task automatic sweep_and_check(input string tag, input int coll, output int wa);
        int n, b, d, w, fa;
        build_expect(coll, n);
        run_sweep(coll, b, d, w, wa, fa);
        chk({tag, " first_addr"}, 64'(fa), 64'd0);
        chk({tag, " busy_cycles"}, 64'(b), 64'(512 + n));
        chk({tag, " done_cycle"}, 64'(d), 64'(513 + n));
        chk({tag, " writes"}, 64'(w), 64'(n));
        @(negedge pclk12);
        chk({tag, " aged_count"}, 64'(aged_count12), 64'(n));
        check_table(tag);
    endtask

    initial begin
        int wa;
        int found;
        logic [31:0] a;
        p_reset12       = 1'b1;
        age_start12     = 1'b0;
        curr_time12     = 32'd0;
        age_thresh12    = 32'd0;
        mem_addr_add12  = 8'd0;
        mem_write_add12 = 1'b0;
        add_data        = '0;
        ld_all          = 1'b0;
        repeat (2) @(negedge pclk12);
        chk("rst addr", 64'(mem_addr_age12), 64'd0);
        chk("rst write", 64'(mem_write_age12), 64'd0);
        chk("rst wdata", 64'(mem_write_data_age12[63:0]), 64'd0);
        chk("rst busy", 64'(sweep_busy12), 64'd0);
        chk("rst done", 64'(sweep_done12), 64'd0);
        chk("rst aged", 64'(aged_count12), 64'd0);
        p_reset12 = 1'b0;

        // All entries invalid.
        fill_invalid(); load_table();
        curr_time12 = 32'd1000; age_thresh12 = 32'd10;
        sweep_and_check("all_invalid", 256, wa);

        // Single stale entry at address 5.
        fill_invalid(); init_tab[5] = {1'b1, 2'b01, 32'd100, 48'h0123_4567_89ab}; load_table();
        curr_time12 = 32'd200; age_thresh12 = 32'd99;
        sweep_and_check("entry5_aged", 256, wa);
        chk("entry5 wr_addr", 64'(wa), 64'd5);

        // Age equal to threshold is not stale.
        fill_invalid(); init_tab[5] = {1'b1, 2'b01, 32'd100, 48'h0123_4567_89ab}; load_table();
        age_thresh12 = 32'd100;
        sweep_and_check("entry5_equal", 256, wa);

        // Timestamp wrap.
        fill_invalid(); init_tab[9] = {1'b1, 2'b10, 32'hffff_fff0, 48'hdead_beef_0001}; load_table();
        curr_time12 = 32'h10; age_thresh12 = 32'h1f;
        sweep_and_check("wrap", 256, wa);

        // Reset in the WR cycle of entry 40.
        for (int i = 0; i < 256; i++) init_tab[i] = mk_entry(1'($urandom), $urandom);
        init_tab[40] = {1'b1, 2'b11, 32'd100, 48'h4040_4040_4040};
        load_table();
        curr_time12 = 32'd5000; age_thresh12 = 32'd1000;
        age_start12 = 1'b1;
        @(negedge pclk12);
        age_start12 = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (sweep_busy12 && mem_addr_age12 == 8'd40) begin
                found = 1;
                break;
            end
            @(negedge pclk12);
        end
        chk("rst40 reached", 64'(found), 64'd1);
        repeat (2) @(negedge pclk12);
        p_reset12 = 1'b1;
        #1;
        chk("rst40 write_forced_low", 64'(mem_write_age12), 64'd0);
        @(negedge pclk12);
        chk("rst40 addr", 64'(mem_addr_age12), 64'd0);
        chk("rst40 write", 64'(mem_write_age12), 64'd0);
        chk("rst40 wdata", 64'(mem_write_data_age12[63:0]), 64'd0);
        chk("rst40 busy", 64'(sweep_busy12), 64'd0);
        chk("rst40 done", 64'(sweep_done12), 64'd0);
        chk("rst40 aged", 64'(aged_count12), 64'd0);
        chk("rst40 entry_kept", 64'(ram[40][82]), 64'd1);
        p_reset12 = 1'b0;
        @(negedge pclk12);
        for (int i = 0; i < 256; i++) init_tab[i] = ram[i];
        sweep_and_check("restart", 256, wa);

        // Add-port write to entry 7 during its check cycle.
        fill_invalid(); init_tab[7] = {1'b1, 2'b00, 32'd100, 48'h0707_0707_0707}; load_table();
        curr_time12 = 32'd200; age_thresh12 = 32'd50;
        add_data = {1'b1, 2'b10, 32'd200, 48'h0000_0000_aaaa};
        sweep_and_check("collision7", 7, wa);

        // Randomised tables with ages straddling the threshold.
        for (int r = 0; r < 3; r++) begin
            curr_time12  = $urandom;
            age_thresh12 = $urandom_range(0, 100000);
            for (int i = 0; i < 256; i++) begin
                a = age_thresh12 + 32'($urandom_range(0, 3)) - 32'd1;
                init_tab[i] = mk_entry(1'($urandom), curr_time12 - a);
            end
            load_table();
            sweep_and_check($sformatf("random%0d", r), 256, wa);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
